// File: rtl/instr_decode_stage_pkg.sv
// Shared decode definitions: instruction type codes, RV32 opcodes, type
// classification and immediate generation used by the decode stage.
package decode_pkg;

    localparam int IMM_W = 32;

    typedef enum logic [3:0] {
        T_R       = 4'd0,
        T_I       = 4'd1,
        T_LUI     = 4'd2,
        T_AUIPC   = 4'd3,
        T_LOAD    = 4'd4,
        T_STORE   = 4'd5,
        T_BRANCH  = 4'd6,
        T_JAL     = 4'd7,
        T_JALR    = 4'd8,
        T_SYSTEM  = 4'd9,
        T_MUL     = 4'd10,
        T_ILLEGAL = 4'd15
    } instr_type_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Codes 11..14 are unassigned; MUL only exists when the M extension is built in.
    function automatic bit type_used(input int code, input bit m_en);
        return (code <= 9) || (code == 15) || (code == 10 && m_en);
    endfunction

    function automatic instr_type_t decode_type(input logic [31:0] instr, input bit m_en);
        instr_type_t t;
        t = T_ILLEGAL;
        case (instr[6:0])
            OP_R:      t = (instr[31:25] == F7_MULDIV) ? (m_en ? T_MUL : T_ILLEGAL) : T_R;
            OP_I:      t = T_I;
            OP_LUI:    t = T_LUI;
            OP_AUIPC:  t = T_AUIPC;
            OP_LOAD:   t = T_LOAD;
            OP_STORE:  t = T_STORE;
            OP_BRANCH: t = T_BRANCH;
            OP_JAL:    t = T_JAL;
            OP_JALR:   t = T_JALR;
            OP_SYSTEM: t = T_SYSTEM;
            default:   t = T_ILLEGAL;
        endcase
        if (instr[1:0] != 2'b11 || instr == 32'h0)
            t = T_ILLEGAL;
        return t;
    endfunction

    function automatic logic [IMM_W-1:0] imm_gen(input logic [31:0] instr, input instr_type_t t);
        logic [IMM_W-1:0] imm;
        imm = '0;
        case (t)
            T_I, T_LOAD, T_JALR, T_SYSTEM:
                imm = {{20{instr[31]}}, instr[31:20]};
            T_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            T_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            T_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            T_LUI, T_AUIPC:
                imm = {instr[31:12], 12'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/instr_decode_stage_counters.sv
// Per-type saturating event counters with synchronous clear and a
// combinational read mux; unassigned type codes have no storage and read 0.
module type_counter_bank
    import decode_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter bit M_EN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic [3:0]       i_inc_type,
    input  logic             i_clr,
    input  logic [3:0]       i_sel,
    output logic [CNT_W-1:0] o_data
);

    logic [CNT_W-1:0] w_cnt [16];

    for (genvar g = 0; g < 16; g++) begin : g_cnt
        if (type_used(g, M_EN)) begin : g_used
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_cnt <= '0;
                else if (i_clr)
                    r_cnt <= '0;
                else if (i_inc && i_inc_type == 4'(g) && r_cnt != '1)
                    r_cnt <= r_cnt + 1'b1;
            end
            assign w_cnt[g] = r_cnt;
        end else begin : g_unused
            assign w_cnt[g] = '0;
        end
    end

    assign o_data = w_cnt[i_sel];

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32 decode stage between fetch and execute, with per-type
// counters and sticky illegal capture. Define DECODE_M_EXT_EN to decode MUL.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_type,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [PC_W-1:0]  out_pc,
    input  logic [3:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_data,
    input  logic             cnt_clr,
    output logic             err_flag,
    output logic [PC_W-1:0]  err_pc,
    input  logic             err_clr
);

`ifdef DECODE_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    instr_type_t      w_type;
    logic [XLEN-1:0]  w_imm;
    logic [4:0]       w_rd, w_rs1, w_rs2;
    logic             w_accept;

    logic             r_out_valid;
    instr_type_t      r_out_type;
    logic [XLEN-1:0]  r_out_imm;
    logic [4:0]       r_out_rd, r_out_rs1, r_out_rs2;
    logic [PC_W-1:0]  r_out_pc;
    logic             r_err_flag;
    logic [PC_W-1:0]  r_err_pc;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    assign w_type = decode_type(in_instr, M_EN);
    assign w_imm  = XLEN'($signed(imm_gen(in_instr, w_type)));

    // Fields are raw slices, zeroed where the instruction format has no such field.
    always_comb begin
        w_rd  = in_instr[11:7];
        w_rs1 = in_instr[19:15];
        w_rs2 = in_instr[24:20];
        if (w_type inside {T_STORE, T_BRANCH})
            w_rd = '0;
        if (w_type inside {T_LUI, T_AUIPC, T_JAL})
            w_rs1 = '0;
        if (!(w_type inside {T_R, T_MUL, T_STORE, T_BRANCH}))
            w_rs2 = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_type  <= T_ILLEGAL;
            r_out_imm   <= '0;
            r_out_rd    <= '0;
            r_out_rs1   <= '0;
            r_out_rs2   <= '0;
            r_out_pc    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_type  <= w_type;
            r_out_imm   <= w_imm;
            r_out_rd    <= w_rd;
            r_out_rs1   <= w_rs1;
            r_out_rs2   <= w_rs2;
            r_out_pc    <= in_pc;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // A new illegal wins over a same-cycle clear so no offending PC is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_flag <= 1'b0;
            r_err_pc   <= '0;
        end else if (w_accept && w_type == T_ILLEGAL && (!r_err_flag || err_clr)) begin
            r_err_flag <= 1'b1;
            r_err_pc   <= in_pc;
        end else if (err_clr) begin
            r_err_flag <= 1'b0;
            r_err_pc   <= '0;
        end
    end

    type_counter_bank #(
        .CNT_W (CNT_W),
        .M_EN  (M_EN)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_accept),
        .i_inc_type (w_type),
        .i_clr      (cnt_clr),
        .i_sel      (cnt_sel),
        .o_data     (cnt_data)
    );

    assign out_valid = r_out_valid;
    assign out_type  = r_out_type;
    assign out_imm   = r_out_imm;
    assign out_rd    = r_out_rd;
    assign out_rs1   = r_out_rs1;
    assign out_rs2   = r_out_rs2;
    assign out_pc    = r_out_pc;
    assign err_flag  = r_err_flag;
    assign err_pc    = r_err_pc;

endmodule
